shift_rd: RTL

Serial-in reader for a 74HC165-style parallel-in/serial-out shift-register chain. It is the input-side counterpart of the LED shift driver: instead of shifting bytes out on a shift clock/data pair, it pulses the chain's parallel-load line, clocks the chain, and deserializes the returned bit stream into a parallel word. It sits beside the LED driver under the TWI/GPIO peripheral and gives the CPU-side register block the state of board switches and keys.

---
 rtl/shift_rd.sv | 108 ++++++++++
 1 files changed

// File: rtl/shift_rd.sv
// shift_rd: 74HC165-style chain reader (parallel load, clock out, deserialize).
// Define SHIFT_RD_SYNC_EN to pass sft_q through a two-flop synchronizer.
module shift_rd #(
    parameter int WIDTH = 8,
    parameter int HALF  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dvld,
    output logic             sft_pl,
    output logic             sft_cp,
    input  logic             sft_q
);

    localparam int PW = $clog2(2 * HALF);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    ph;
    logic [BW-1:0]    bits;
    logic [WIDTH-1:0] shreg;
    logic             q_s;

`ifdef SHIFT_RD_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], sft_q};
        end
    end

    assign q_s = sync[1];
`else
    assign q_s = sft_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ph     <= '0;
            bits   <= '0;
            shreg  <= '0;
            dout   <= '0;
            dvld   <= 1'b0;
            busy   <= 1'b0;
            sft_pl <= 1'b1;
            sft_cp <= 1'b0;
        end else begin
            dvld <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        sft_pl <= 1'b0;
                        busy   <= 1'b1;
                        ph     <= '0;
                    end
                end
                S_LOAD: begin
                    if (ph == PW'(HALF - 1)) begin
                        state  <= S_SHIFT;
                        sft_pl <= 1'b1;
                        ph     <= '0;
                        bits   <= '0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // sample on the last low cycle, then raise the shift clock
                    if (ph == PW'(HALF - 1)) begin
                        shreg  <= (shreg << 1) | WIDTH'(q_s);
                        sft_cp <= 1'b1;
                    end
                    if (ph == PW'(2 * HALF - 1)) begin
                        sft_cp <= 1'b0;
                        ph     <= '0;
                        bits   <= bits + 1'b1;
                        if (bits == BW'(WIDTH - 1)) begin
                            state <= S_DONE;
                            dout  <= shreg;
                            dvld  <= 1'b1;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
